// File: rtl/quad_encoder_gen.sv
// Quadrature A/B waveform generator: emits whole detents per command
// and tracks the position a correct decoder would report.
module quad_encoder_gen #(
  parameter int COUNT_WIDTH = 8,
  parameter int TIME_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_dir,
  input  logic [COUNT_WIDTH-1:0] cmd_steps,
  input  logic [TIME_WIDTH-1:0]  cmd_phase_time,
  output logic                   a,
  output logic                   b,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] position
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             phase_q, phase_d;
  logic [TIME_WIDTH-1:0]  timer_q, timer_d;
  logic [TIME_WIDTH-1:0]  period_q, period_d;
  logic [COUNT_WIDTH-1:0] steps_q, steps_d;
  logic [COUNT_WIDTH-1:0] pos_q, pos_d;
  logic                   dir_q, dir_d;
  logic                   a_q, a_d;
  logic                   b_q, b_d;
  logic                   ready_q, ready_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      phase_q  <= 2'd0;
      timer_q  <= '0;
      period_q <= '0;
      steps_q  <= '0;
      pos_q    <= '0;
      dir_q    <= 1'b0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      timer_q  <= timer_d;
      period_q <= period_d;
      steps_q  <= steps_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    timer_d  = timer_q;
    period_d = period_q;
    steps_d  = steps_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    a_d      = a_q;
    b_d      = b_q;
    ready_d  = ready_q;
    unique case (state_q)
      IDLE: begin
        // Zero-step commands are consumed without leaving IDLE.
        if (cmd_valid && ready_q && cmd_steps != '0) begin
          state_d  = RUN;
          ready_d  = 1'b0;
          dir_d    = cmd_dir;
          steps_d  = cmd_steps;
          phase_d  = 2'd0;
          period_d = (cmd_phase_time == '0) ?
                     TIME_WIDTH'(1) : cmd_phase_time;
          timer_d  = period_d;
        end
      end
      RUN: begin
        if (timer_q == TIME_WIDTH'(1)) begin
          phase_d = phase_q + 2'd1;
          timer_d = period_q;
          // Gray map: the leading channel toggles on odd phases.
          if (dir_q) begin
            a_d = phase_d[1] ^ phase_d[0];
            b_d = phase_d[1];
          end else begin
            a_d = phase_d[1];
            b_d = phase_d[1] ^ phase_d[0];
          end
          if (phase_d == 2'd0) begin
            pos_d   = dir_q ? pos_q + COUNT_WIDTH'(1)
                            : pos_q - COUNT_WIDTH'(1);
            steps_d = steps_q - COUNT_WIDTH'(1);
            if (steps_q == COUNT_WIDTH'(1)) begin
              state_d = IDLE;
              ready_d = 1'b1;
            end
          end
        end else begin
          timer_d = timer_q - TIME_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = (state_q == RUN);
  assign cmd_ready = ready_q;
  assign position  = pos_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed + random bench for quad_encoder_gen against a
// closed-form model: transitions done = floor(elapsed / T).
module tb_quad_encoder_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [7:0] cmd_steps;
  logic [15:0] cmd_phase_time;
  logic       a;
  logic       b;
  logic       busy;
  logic [7:0] position;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_pos = 8'd0;

  quad_encoder_gen #(.COUNT_WIDTH(8), .TIME_WIDTH(16)) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir),
    .cmd_steps(cmd_steps),
    .cmd_phase_time(cmd_phase_time),
    .a(a),
    .b(b),
    .busy(busy),
    .position(position)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {a,b} after k transitions of a command in direction d
  function automatic logic [1:0] gray(input bit d, input int k);
    logic [1:0] up_tab [4];
    logic [1:0] dn_tab [4];
    up_tab = '{2'b00, 2'b10, 2'b11, 2'b01};
    dn_tab = '{2'b00, 2'b01, 2'b11, 2'b10};
    return d ? up_tab[k % 4] : dn_tab[k % 4];
  endfunction

  // observed/expected packed as {a,b,busy,cmd_ready,position}
  task automatic chk(input string tag, input logic [11:0] obs,
                     input logic [11:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {a, b, busy, cmd_ready, position};
  endfunction

  task automatic chk_idle(input string tag);
    chk(tag, outs(), {2'b00, 1'b0, 1'b1, exp_pos});
  endtask

  // Issue one command and check every edge until it completes.
  // abort_c > 0 pulses reset on that elapsed edge.
  // hold keeps cmd_valid high with a different command presented.
  task automatic run_cmd(input string tag, input bit d, input int st,
                         input int pt, input int abort_c,
                         input bit hold, input bit nd, input int nst,
                         input int npt);
    int t;
    int n;
    int k;
    logic [7:0] p0;
    logic [7:0] pe;
    bit bz;
    t = (pt == 0) ? 1 : pt;
    n = 4 * st;
    p0 = exp_pos;
    cmd_valid = 1'b1;
    cmd_dir = d;
    cmd_steps = 8'(st);
    cmd_phase_time = 16'(pt);
    step();
    if (hold) begin
      cmd_dir = nd;
      cmd_steps = 8'(nst);
      cmd_phase_time = 16'(npt);
    end else begin
      cmd_valid = 1'b0;
    end
    bz = (st != 0);
    chk({tag, "_accept"}, outs(), {2'b00, bz, !bz, p0});
    if (st == 0) begin
      for (int i = 0; i < 3; i++) begin
        step();
        chk({tag, "_zero"}, outs(), {2'b00, 1'b0, 1'b1, p0});
      end
      return;
    end
    for (int c = 1; c <= n * t; c++) begin
      if (c == abort_c) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_pos = 8'd0;
        chk({tag, "_reset"}, outs(), {2'b00, 1'b0, 1'b1, 8'd0});
        for (int i = 0; i < 8; i++) begin
          step();
          chk({tag, "_after_reset"}, outs(),
              {2'b00, 1'b0, 1'b1, 8'd0});
        end
        return;
      end
      step();
      k = c / t;
      pe = d ? p0 + 8'(k / 4) : p0 - 8'(k / 4);
      bz = (k < n);
      chk(tag, outs(), {gray(d, k), bz, !bz, pe});
    end
    exp_pos = d ? p0 + 8'(st) : p0 - 8'(st);
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_dir = 1'b0;
    cmd_steps = 8'd0;
    cmd_phase_time = 16'd0;
    step();
    step();
    reset = 1'b0;
    chk_idle("reset");
    for (int i = 0; i < 10; i++) begin
      step();
      chk_idle("idle");
    end

    run_cmd("up1_t3", 1'b1, 1, 3, 0, 1'b0, 1'b0, 0, 0);
    run_cmd("dn2_t0", 1'b0, 2, 0, 0, 1'b0, 1'b0, 0, 0);
    run_cmd("zero_steps", 1'b1, 0, 5, 0, 1'b0, 1'b0, 0, 0);
    step();
    chk_idle("zero_gap");

    run_cmd("up5_t4_held", 1'b1, 5, 4, 0, 1'b1, 1'b0, 2, 3);
    run_cmd("second_cmd", 1'b0, 2, 3, 0, 1'b0, 1'b0, 0, 0);
    step();
    chk_idle("gap");

    // 5th transition lands on elapsed 10; reset on edge 11
    run_cmd("up3_abort", 1'b1, 3, 2, 11, 1'b0, 1'b0, 0, 0);
    run_cmd("up1_post", 1'b1, 1, 1, 0, 1'b0, 1'b0, 0, 0);

    run_cmd("max_steps", 1'b1, 255, 0, 0, 1'b0, 1'b0, 0, 0);

    for (int r = 0; r < 12; r++) begin
      int idle_n;
      run_cmd("rand", 1'($urandom_range(1)),
              int'($urandom_range(4)), int'($urandom_range(3)),
              0, 1'b0, 1'b0, 0, 0);
      idle_n = int'($urandom_range(2));
      for (int i = 0; i < idle_n; i++) begin
        step();
        chk_idle("rand_gap");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/quad_encoder_gen.md
Name: quad_encoder_gen

Overview:
- Generates quadrature A/B waveforms, the transmit side of the rotary-encoder interface that the debounce+encoder chain decodes.
- Accepts a command (direction, number of detents, phase time) over a valid/ready handshake and emits the matching Gray-code sequence.
- Drives the encoder inputs in system-level benches and on the demo board's loopback header.
- Keeps a wrapping position count that mirrors the value a correct decoder reports.

Parameters:
- COUNT_WIDTH, 8, width of cmd_steps and of position.
- TIME_WIDTH, 16, width of cmd_phase_time.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_dir  input  1  1 = up (A leads B), 0 = down (B leads A)
- cmd_steps  input  COUNT_WIDTH  number of detents (full 4-transition cycles)
- cmd_phase_time  input  TIME_WIDTH  clocks between successive A/B transitions
- a  output  1  quadrature channel A
- b  output  1  quadrature channel B
- busy  output  1  command in progress
- position  output  COUNT_WIDTH  detent count, wraps modulo 2^COUNT_WIDTH

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values: a=0, b=0, busy=0, cmd_ready=1, position=0. The internal phase is 0, the timer is 0 and steps remaining is 0.
- Handshake:
  - A command is accepted on a rising edge where cmd_valid && cmd_ready.
  - cmd_dir, cmd_steps and cmd_phase_time are latched at acceptance.
  - cmd_ready = !busy and is registered; it equals ~busy at every cycle.
  - Inputs are ignored while busy. No queueing.
- States:
  - IDLE: waiting for a command. On accept with cmd_steps != 0, go to RUN, set busy=1, cmd_ready=0, load the timer with the effective phase time T and load steps remaining.
  - On accept with cmd_steps == 0: no state change and no output change. cmd_ready stays 1.
  - RUN: the timer decrements each clock. When it reaches 1, perform one transition on that edge and reload the timer with T.
- Effective phase time: T = cmd_phase_time, except T = 1 when cmd_phase_time == 0.
- Timing: the first transition occurs on edge N+T, where N is the accept edge. Transition k (k = 1..4*steps) occurs on edge N+k*T.
- Transition sequence, phase 0..3 as {a,b}:
  - Up: 00 -> 10 -> 11 -> 01 -> 00.
  - Down: 00 -> 01 -> 11 -> 10 -> 00.
  - Exactly one of a/b changes per transition. No glitches.
- Position:
  - Updates on the same edge as the 4th transition of each detent (return to 00).
  - Up adds 1 and down subtracts 1, both modulo 2^COUNT_WIDTH (255+1 -> 0; 0-1 -> 255).
- Completion:
  - On the edge of the final transition, busy drops to 0 and cmd_ready rises to 1.
  - a=b=0 at that point, because the block always ends on a full cycle.
  - The next command's first transition is ≥ T clocks later, so consecutive commands never violate minimum phase spacing.
- Direction: a direction change between commands is legal. Each command starts from phase 00.
- Reset mid-RUN: the command is abandoned. On that edge a=b=0, busy=0, cmd_ready=1 and position=0. Partial detents are not counted.
- Width rules: the timer is TIME_WIDTH bits. The steps-remaining counter is COUNT_WIDTH bits; cmd_steps = 2^COUNT_WIDTH-1 is legal and produces exactly that many detents.
- Debounce compatibility: callers choose a cmd_phase_time larger than the downstream debounce settle time. The block does not enforce this.

Test Plan:
1. Reset, then idle 10 cycles -> a=0, b=0, busy=0, cmd_ready=1, position=0 throughout.
2. Up, steps=1, phase_time=3, accepted at edge N:
   - {a,b} = 10 at N+3, 11 at N+6, 01 at N+9, 00 at N+12.
   - position=1 and busy=0 at N+12.
3. Down, steps=2, phase_time=0 (treated as 1) from position 1:
   - 8 transitions, one per clock, sequence 01,11,10,00,01,11,10,00.
   - position goes 0 then 255.
   - busy high for exactly 8 cycles.
4. cmd_steps=0 with cmd_valid held 1 cycle -> accepted; a, b, position unchanged; busy never asserts.
5. Up, steps=5, phase_time=4, with cmd_valid held high and a different command presented mid-run:
   - The second command is not accepted until busy=0.
   - The first command completes with position +5.
   - The second command is then accepted with cmd_ready=1.
6. Up, steps=3, phase_time=2; assert reset during the 6th transition's interval:
   - The next edge gives a=b=0, busy=0, position=0.
   - No further transitions occur.
   - A subsequent up, steps=1 runs normally to position=1.
